fetch_unit: RTL and testbench

//  Program-counter and instruction-register stage. It drives the word address into the

---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program-counter / instruction-register stage: drives the ROM word address, captures the
// returned word and offers {instruction, pc} to decode over a valid/ready handshake.
module fetch_unit #(
  parameter int                  ADDR_W   = 6,
  parameter int                  DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int                  PROG_LEN = 12,
  parameter int                  CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
  // One bit wider so PROG_LEN == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   PROG_END = (ADDR_W + 1)'(PROG_LEN);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              capture;
  logic              target_in_range;

  assign rom_addr        = pc;
  assign target_in_range = {1'b0, redirect_addr} < PROG_END;
  assign capture         = (state == RUN) & en & (~ir_valid | ir_ready) & ~redirect;

  // NOTE: all state is updated with non-blocking assignments so every register sees the
  // pre-edge values of the others, exactly as the flops do in hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      ir_valid  <= 1'b0;
      ir_data   <= '0;
      ir_pc     <= '0;
      halted    <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        // rom_data is stale for the first cycle after reset release, so nothing is captured.
        BOOT: begin
          state  <= RUN;
          halted <= 1'b0;
          if (redirect) pc <= redirect_addr;
        end
        default: begin
          if (redirect) begin
            ir_valid <= 1'b0;
            pc       <= redirect_addr;
            if (target_in_range) begin
              state  <= RUN;
              halted <= 1'b0;
            end else begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end else if (capture) begin
            ir_data  <= rom_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + CNT_W'(1);
            // The last program word parks pc so it can never wrap past the program.
            if (pc == LAST_PC) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc + ADDR_W'(1);
            end
          end else if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, every cycle compared
// against a cycle-level program model that fetches straight from the program array.
module tb_fetch_unit;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;
  localparam int PROG_LEN = 12;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              ir_valid;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              halted;
  logic [CNT_W-1:0]  fetch_cnt;

  fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0), .PROG_LEN(PROG_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rom_addr(rom_addr), .rom_data(rom_data),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] prog [PROG_LEN] = '{
    32'h13a0000c, 32'he3a01004, 32'h33a05000, 32'ha3a01001,
    32'he3a02002, 32'he0813002, 32'he2522001, 32'h1afffffc,
    32'h2afffffc, 32'he1a00000, 32'he3a0600f, 32'he1016090
  };
  logic [DATA_W-1:0] rom [1 << ADDR_W];

  always @(negedge clk) rom_data <= rom[rom_addr];

  int n_vec = 0;
  int n_err = 0;

  // Program-level model: where the pc is, what decode holds, whether fetching has stopped.
  int                m_pc, m_ir_pc, m_cnt;
  logic [DATA_W-1:0] m_data;
  bit                m_boot, m_halt, m_valid;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir_pc = 0; m_cnt = 0; m_data = '0;
    m_boot = 1; m_halt = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    if (m_boot) begin
      m_boot = 0;
      if (redirect) m_pc = int'(redirect_addr);
    end else if (redirect) begin
      m_valid = 0;
      m_pc    = int'(redirect_addr);
      m_halt  = (m_pc >= PROG_LEN);
    end else if (!m_halt && en && (!m_valid || ir_ready)) begin
      m_data  = prog[m_pc % PROG_LEN];
      m_ir_pc = m_pc;
      m_valid = 1;
      m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (m_pc == PROG_LEN - 1) m_halt = 1;
      else m_pc = m_pc + 1;
    end else if (m_valid && ir_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("ir_valid", ir_valid, m_valid);
    check("ir_data", ir_data, m_data);
    check("ir_pc", ir_pc, m_ir_pc);
    check("rom_addr", rom_addr, m_pc);
    check("halted", halted, m_halt);
    check("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_until_pc(int p);
    int budget = 40;
    while (!(m_valid && m_ir_pc == p) && budget > 0) begin
      step();
      budget--;
    end
    check("reach_pc", ir_pc, p);
    check("reach_valid", ir_valid, 1);
  endtask

  // Called 1 time unit after a posedge; asserts reset mid-cycle, releases it after a negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", ir_valid, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_cnt", fetch_cnt, 0);
    check("rst_halted", halted, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++)
      rom[i] = (i < PROG_LEN) ? prog[i] : {16'hbad0, 16'(i)};
    en = 1'b1; ir_ready = 1'b1; redirect = 1'b0; redirect_addr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Straight-line run to the end of the program.
    step();
    step();
    check("t1_first", ir_data, 32'h13a0000c);
    repeat (12) step();
    check("t1_halt", halted, 1);
    check("t1_cnt", fetch_cnt, 12);

    // Back-pressure at pc3.
    redirect = 1'b1; redirect_addr = 6'd0;
    step();
    redirect = 1'b0;
    run_until_pc(3);
    ir_ready = 1'b0;
    repeat (3) step();
    check("t2_data", ir_data, 32'ha3a01001);
    check("t2_pc", ir_pc, 3);
    check("t2_addr", rom_addr, 4);
    ir_ready = 1'b1;
    step();
    check("t2_next_pc", ir_pc, 4);
    check("t2_next_data", ir_data, 32'he3a02002);

    // Redirect while pc2 is valid.
    redirect = 1'b1; redirect_addr = 6'd0;
    step();
    redirect = 1'b0;
    run_until_pc(2);
    redirect = 1'b1; redirect_addr = 6'd8;
    step();
    check("t3_flush", ir_valid, 0);
    redirect = 1'b0;
    step();
    check("t3_pc", ir_pc, 8);
    check("t3_data", ir_data, 32'h2afffffc);

    // Redirect during a stall, then in the same cycle as ir_ready.
    ir_ready = 1'b0;
    step();
    redirect = 1'b1; redirect_addr = 6'd1;
    step();
    check("t4_stall_flush", ir_valid, 0);
    redirect = 1'b0;
    step();
    check("t4_stall_target", ir_pc, 1);
    ir_ready = 1'b1; redirect = 1'b1; redirect_addr = 6'd5;
    step();
    check("t4_rdy_flush", ir_valid, 0);
    redirect = 1'b0;
    step();
    check("t4_rdy_target", ir_pc, 5);

    // Redirect past the program end halts; a later redirect restarts.
    redirect = 1'b1; redirect_addr = 6'd12;
    step();
    check("t5_halted", halted, 1);
    check("t5_valid", ir_valid, 0);
    redirect = 1'b0;
    repeat (3) step();
    check("t5_no_fetch", ir_valid, 0);
    redirect = 1'b1; redirect_addr = 6'd0;
    step();
    check("t5_resume", halted, 0);
    redirect = 1'b0;
    step();
    check("t5_data", ir_data, 32'h13a0000c);

    // Asynchronous reset mid-run, then an en=0 freeze.
    run_until_pc(5);
    do_reset();
    step();
    check("t6_boot", ir_valid, 0);
    step();
    check("t6_pc0", ir_pc, 0);
    check("t6_data", ir_data, 32'h13a0000c);
    en = 1'b0;
    repeat (2) step();
    check("t6_frozen", rom_addr, 1);
    check("t6_cnt", fetch_cnt, 1);
    en = 1'b1;

    // Randomized traffic, including out-of-range redirects and occasional resets.
    repeat (400) begin
      en            = ($urandom_range(0, 9) != 0);
      ir_ready      = ($urandom_range(0, 9) < 7);
      redirect      = ($urandom_range(0, 19) == 0);
      redirect_addr = 6'($urandom_range(0, 15));
      if (m_boot && redirect_addr >= PROG_LEN) redirect = 1'b0;
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
